// File: rtl/arb_pkg.sv
// Shared defaults and FSM encoding for the request capture arbiter.
package arb_pkg;

    localparam int N_REQ_DEF  = 8;
    localparam int IDX_W_DEF  = 3;
    localparam int DCNT_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first set bit of mask, scanning upward from ptr with wrap (ARB_ROUND_ROBIN_EN),
// or lowest set bit (fixed priority). Zero latency, no flow control.
module rr_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

`ifdef ARB_ROUND_ROBIN_EN
    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && mask[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end
`else
    // Fixed priority ignores the pointer entirely.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && mask[i]) begin
                any       = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/req_capture_arbiter.sv
// Captures request pulses into a sticky pending set and issues one registered grant at a time (ARB_ROUND_ROBIN_EN: round-robin, else fixed priority).
// Latency: req at edge t -> pend at t -> gnt_valid after t+1; one grant per cycle back-to-back.
// Backpressure: grant held stable while gnt_ready is low; requests keep accumulating, repeats counted as drops.
module req_capture_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DCNT_W = DCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              gnt_ready,
    output logic              gnt_valid,
    output logic [N_REQ-1:0]  gnt_onehot,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic [N_REQ-1:0]  pend,
    output logic [DCNT_W-1:0] drop_cnt
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;

    logic             accept;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] set_v;
    logic [N_REQ-1:0] pend_nxt;
    logic             drop;
    logic [IDX_W-1:0] nxt_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign accept   = (state == GRANT) && gnt_ready;
    assign clr      = accept ? gnt_onehot : '0;
    assign set_v    = req & {N_REQ{en}};
    assign pend_nxt = (pend & ~clr) | set_v;
    assign drop     = |(set_v & pend & ~clr);
    assign nxt_ptr  = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Only registered pend is eligible; on an accept the leaving bit is masked so the next grant can load on the same edge.
    assign pick_mask = (state == GRANT) ? (pend & ~clr) : pend;
    assign pick_ptr  = (state == GRANT) ? nxt_ptr : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
        end else begin
            pend <= pend_nxt;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DCNT_W'(1);

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_onehot <= pick_onehot;
                        gnt_idx    <= pick_idx;
                    end
                end
                GRANT: begin
                    if (accept) begin
`ifdef ARB_ROUND_ROBIN_EN
                        ptr <= nxt_ptr;
`else
                        ptr <= '0;
`endif
                        if (pick_any) begin
                            gnt_onehot <= pick_onehot;
                            gnt_idx    <= pick_idx;
                        end else begin
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                            gnt_idx    <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                    gnt_idx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_capture_arbiter.sv
// Bench for req_capture_arbiter: table of request bursts with hand-derived grant orders, plus hold/drop/reset sequences.
module tb_req_capture_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [7:0] gnt_onehot;
    logic [2:0] gnt_idx;
    logic [7:0] pend;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_e;
    int d;
    logic [31:0] seq;

    typedef struct {
        logic [7:0]  req;
        int          n;
        logic [31:0] rr;   // grant order, one hex digit per grant, first grant most significant
        logic [31:0] fx;
    } vec_t;

    vec_t tbl[9];

    req_capture_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .pend       (pend),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every accepted handshake pops the next expected grant.
    always begin
        @(negedge clk);
        #3;
        if (!rst && gnt_valid && gnt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant actual=%0d expected=none", gnt_idx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant_idx", 32'(gnt_idx), 32'(mon_e));
                chk("grant_onehot", 32'(gnt_onehot), 32'(1 << mon_e));
            end
        end
    end

    initial begin
        tbl[0] = '{8'hFF, 8, 32'h01234567, 32'h01234567};
        tbl[1] = '{8'h10, 1, 32'h4,        32'h4};
        tbl[2] = '{8'h30, 2, 32'h54,       32'h45};
        tbl[3] = '{8'h04, 1, 32'h2,        32'h2};
        tbl[4] = '{8'h05, 2, 32'h02,       32'h02};
        tbl[5] = '{8'h81, 2, 32'h70,       32'h07};
        tbl[6] = '{8'h0A, 2, 32'h13,       32'h13};
        tbl[7] = '{8'h60, 2, 32'h56,       32'h56};
        tbl[8] = '{8'h03, 2, 32'h01,       32'h01};

        rst = 1'b1; en = 1'b1; req = '0; gnt_ready = 1'b1;
        cyc();
        chk("rst_valid", 32'(gnt_valid), 0);
        chk("rst_onehot", 32'(gnt_onehot), 0);
        chk("rst_idx", 32'(gnt_idx), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0;
        cyc();

        // Capture disabled: requests ignored.
        en = 1'b0; req = 8'hFF;
        cyc();
        req = '0;
        chk("en_off_pend", 32'(pend), 0);
        cyc();
        chk("en_off_valid", 32'(gnt_valid), 0);
        en = 1'b1;

        for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            seq = tbl[k].rr;
`else
            seq = tbl[k].fx;
`endif
            for (int m = 0; m < tbl[k].n; m++) begin
                d = int'((seq >> (4 * (tbl[k].n - 1 - m))) & 32'h7);
                exp_q.push_back(d);
            end
            req = tbl[k].req;
            cyc();
            req = '0;
            chk("capture_pend", 32'(pend), 32'(tbl[k].req));
            chk("capture_no_valid", 32'(gnt_valid), 0);
            cyc();
            for (int m = 0; m < tbl[k].n; m++) begin
                chk("b2b_valid", 32'(gnt_valid), 1);
                cyc();
            end
            chk("drain_valid", 32'(gnt_valid), 0);
            chk("drain_pend", 32'(pend), 0);
            chk("drain_idx", 32'(gnt_idx), 0);
        end

        // Hold: grant 6 stalled while req[1] arrives, then 1 follows back-to-back.
        exp_q.push_back(6);
        exp_q.push_back(1);
        gnt_ready = 1'b0; req = 8'h40;
        cyc();
        req = '0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            req = (i == 1) ? 8'h02 : 8'h00;
            chk("hold_valid", 32'(gnt_valid), 1);
            chk("hold_onehot", 32'(gnt_onehot), 32'h40);
            cyc();
        end
        req = '0;
        chk("hold_pend", 32'(pend), 32'h42);
        gnt_ready = 1'b1;
        cyc();
        chk("hold_next_valid", 32'(gnt_valid), 1);
        chk("hold_next_idx", 32'(gnt_idx), 1);
        cyc();
        chk("hold_end_valid", 32'(gnt_valid), 0);
        chk("hold_end_pend", 32'(pend), 0);

        // Drops while grant 2 is held; re-request on the accept edge is not a drop.
        exp_q.push_back(2);
        exp_q.push_back(2);
        gnt_ready = 1'b0; req = 8'h04;
        repeat (10) cyc();
        chk("drop_nine", 32'(drop_cnt), 9);
        chk("drop_gnt_idx", 32'(gnt_idx), 2);
        gnt_ready = 1'b1;
        cyc();
        chk("reaccept_drop", 32'(drop_cnt), 9);
        chk("reaccept_pend", 32'(pend), 32'h04);
        chk("reaccept_valid", 32'(gnt_valid), 0);
        gnt_ready = 1'b0;
        repeat (289) cyc();
        chk("drop_sat", 32'(drop_cnt), 255);
        chk("drop_sat_valid", 32'(gnt_valid), 1);
        chk("drop_sat_idx", 32'(gnt_idx), 2);
        req = '0; gnt_ready = 1'b1;
        cyc();
        chk("drop_end_valid", 32'(gnt_valid), 0);
        chk("drop_end_pend", 32'(pend), 0);
        chk("drop_end_cnt", 32'(drop_cnt), 255);

        // Asynchronous reset mid-handshake.
        gnt_ready = 1'b0; req = 8'hFF;
        cyc();
        req = '0;
        cyc();
        chk("prerst_valid", 32'(gnt_valid), 1);
        chk("prerst_pend", 32'(pend), 32'hFF);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(gnt_valid), 0);
        chk("arst_pend", 32'(pend), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        chk("arst_idx", 32'(gnt_idx), 0);
        chk("arst_onehot", 32'(gnt_onehot), 0);
        cyc();
        rst = 1'b0; gnt_ready = 1'b1;
        cyc();
        cyc();
        chk("post_rst_valid", 32'(gnt_valid), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
